// File: rtl/counter_pkg.sv
// Shared definitions for the counters library.
// Holds direction/mode encodings and the elaboration-time legality check
// used by parametrised counters.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam int unsigned MaxWidth = 16;

  // True when the width/modulus pair is a supported configuration.
  function automatic bit params_legal(int unsigned width, int unsigned modulus);
    if (width < 1 || width > MaxWidth) begin
      return 1'b0;
    end
    return (modulus >= 2) && (modulus <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/d_ff_n.sv
// Width-bit D register with asynchronous active-low reset to zero.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   d_i    - next value
//   q_o    - registered value
module d_ff_n #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sync_updown_mod_counter.sv
// Parametrised synchronous up/down modulo counter with load, enable and
// wrap/saturate mode. Count range is 0..MODULUS-1.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset (q and wrap clear)
//   en_i       - count enable
//   up_dn_i    - direction, 1 = up, 0 = down
//   mode_i     - 0 = wrap at terminal value, 1 = saturate
//   load_i     - synchronous load strobe, has priority over en_i
//   load_val_i - value to load, clamped to MODULUS-1
//   q_o        - current count, registered
//   tc_o       - terminal count for the current direction, combinational
//   wrap_o     - one-cycle pulse coincident with q showing the wrapped value
module sync_updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("sync_updown_mod_counter: illegal WIDTH/MODULUS combination");
  end

  // Arithmetic runs one bit wider so MODULUS = 2**WIDTH needs no special case.
  localparam logic [WIDTH:0] TermUp = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0] One    = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   q_ext, lv_ext, inc_ext, dec_ext;
  logic             tc;

  d_ff_n #(
    .Width(WIDTH)
  ) u_q_reg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (q_d),
    .q_o   (q_q)
  );

  always_comb begin
    q_ext   = {1'b0, q_q};
    lv_ext  = {1'b0, load_val_i};
    inc_ext = q_ext + One;
    dec_ext = q_ext - One;
    tc      = (up_dn_i == DIR_UP) ? (q_ext == TermUp) : (q_ext == '0);
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load_i) begin
      q_d = (lv_ext > TermUp) ? TermUp[WIDTH-1:0] : load_val_i;
    end else if (en_i) begin
      if (tc) begin
        if (mode_i == MODE_WRAP) begin
          q_d    = (up_dn_i == DIR_UP) ? '0 : TermUp[WIDTH-1:0];
          wrap_d = 1'b1;
        end
      end else if (up_dn_i == DIR_UP) begin
        q_d = inc_ext[WIDTH-1:0];
      end else begin
        q_d = dec_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = q_q;
  assign tc_o   = tc;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
module tb_sync_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_dn, mode, load;
  logic [3:0] load_val;

  logic [3:0] qa;
  logic       tca, wrapa;
  logic [2:0] qb;
  logic       tcb, wrapb;
  logic [0:0] qc;
  logic       tcc, wrapc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .mode_i(mode),
    .load_i(load), .load_val_i(load_val), .q_o(qa), .tc_o(tca), .wrap_o(wrapa)
  );

  sync_updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .mode_i(mode),
    .load_i(load), .load_val_i(load_val[2:0]), .q_o(qb), .tc_o(tcb), .wrap_o(wrapb)
  );

  sync_updown_mod_counter #(.WIDTH(1), .MODULUS(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .mode_i(mode),
    .load_i(load), .load_val_i(load_val[0:0]), .q_o(qc), .tc_o(tcc), .wrap_o(wrapc)
  );

  // Reference model: plain integer counters, one per DUT.
  int    mod_k[3] = '{10, 8, 2};
  int    wid_k[3] = '{4, 3, 1};
  string tag_k[3] = '{"A", "B", "C"};
  int    mq[3];
  bit    mw[3];
  int    cyc = 0;

  typedef struct {
    bit   en;
    bit   up;
    bit   mode;
    bit   load;
    int   lv;
    int   q;
    bit   wrap;
    bit   tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit e, bit u, bit m, bit l, int lv, int q, bit w, bit t);
    vec_t v;
    v.en = e; v.up = u; v.mode = m; v.load = l; v.lv = lv; v.q = q; v.wrap = w; v.tc = t;
    vecs.push_back(v);
  endfunction

  function automatic int act_q(int k);
    case (k)
      0:       return int'(qa);
      1:       return int'(qb);
      default: return int'(qc);
    endcase
  endfunction

  function automatic int act_w(int k);
    case (k)
      0:       return int'(wrapa);
      1:       return int'(wrapb);
      default: return int'(wrapc);
    endcase
  endfunction

  function automatic int act_tc(int k);
    case (k)
      0:       return int'(tca);
      1:       return int'(tcb);
      default: return int'(tcc);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_in(input bit e, input bit u, input bit m, input bit l, input int lv);
    en = e; up_dn = u; mode = m; load = l; load_val = 4'(lv);
  endtask

  // tc is checked a moment after inputs settle, against the model's count.
  task automatic chk_tc();
    #1;
    for (int k = 0; k < 3; k++) begin
      int exp_tc;
      exp_tc = up_dn ? int'(mq[k] == mod_k[k] - 1) : int'(mq[k] == 0);
      chk($sformatf("%s.tc cyc %0d", tag_k[k], cyc), act_tc(k), exp_tc);
    end
  endtask

  // Advance one clock: predict from the inputs in force, then compare q/wrap.
  task automatic tick();
    int nq[3];
    bit nw[3];
    for (int k = 0; k < 3; k++) begin
      int m, lv;
      m     = mod_k[k];
      lv    = int'(load_val) % (1 << wid_k[k]);
      nq[k] = mq[k];
      nw[k] = 1'b0;
      if (load) begin
        nq[k] = (lv < m) ? lv : m - 1;
      end else if (en) begin
        if (up_dn) begin
          if (mq[k] < m - 1)  nq[k] = mq[k] + 1;
          else if (!mode) begin nq[k] = 0; nw[k] = 1'b1; end
        end else begin
          if (mq[k] > 0)      nq[k] = mq[k] - 1;
          else if (!mode) begin nq[k] = m - 1; nw[k] = 1'b1; end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      mq[k] = rst_n ? nq[k] : 0;
      mw[k] = rst_n ? nw[k] : 1'b0;
      chk($sformatf("%s.q cyc %0d", tag_k[k], cyc), act_q(k), mq[k]);
      chk($sformatf("%s.wrap cyc %0d", tag_k[k], cyc), act_w(k), int'(mw[k]));
    end
  endtask

  initial begin
    int wraps;
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #3;
    chk("reset A.q", int'(qa), 0);
    chk("reset A.wrap", int'(wrapa), 0);
    chk("reset A.tc down", int'(tca), 1);
    up_dn = 1'b1;
    #1;
    chk("reset A.tc up", int'(tca), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A: WIDTH=4, MODULUS=10 expectations.
    add(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(1, 1, 0, 0, 0, i, 0, i == 9);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 9, 1, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0);
    add(1, 1, 0, 1, 13, 9, 0, 1);
    add(0, 1, 0, 1, 4, 4, 0, 0);
    add(0, 1, 0, 1, 7, 7, 0, 0);
    add(1, 1, 1, 0, 0, 8, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0, 9, 0, 1);
    add(0, 0, 1, 1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 9, 1, 0);
    add(0, 0, 0, 0, 0, 9, 0, 0);
    add(1, 1, 0, 1, 15, 9, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 10, 9, 0, 1);

    foreach (vecs[i]) begin
      set_in(vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].load, vecs[i].lv);
      tick();
      chk($sformatf("vec %0d A.q", i), int'(qa), vecs[i].q);
      chk($sformatf("vec %0d A.wrap", i), int'(wrapa), int'(vecs[i].wrap));
      chk($sformatf("vec %0d A.tc", i), int'(tca), int'(vecs[i].tc));
    end

    // MODULUS=2 held counting up: wrap every other cycle.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk_tc();
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wraps += int'(wrapc);
    end
    chk("C continuous wraps", wraps, 4);

    // Random enable, occasional loads/mode changes, direction flips at A=5.
    for (int i = 0; i < 400; i++) begin
      bit e, u, m, l;
      e = 1'($urandom_range(0, 1));
      u = up_dn;
      if (mq[0] == 5) u = ~u;
      m = ($urandom_range(0, 15) == 0) ? ~mode : mode;
      l = ($urandom_range(0, 15) == 0);
      set_in(e, u, m, l, int'($urandom_range(0, 15)));
      chk_tc();
      tick();
    end

    // Asynchronous reset mid-cycle while a load is pending at q=6.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 6);
    tick();
    chk("pre-reset A.q", int'(qa), 6);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst A.q", int'(qa), 0);
    chk("async rst A.wrap", int'(wrapa), 0);
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 0);
    tick();
    chk("post-reset A.q", int'(qa), 1);
    tick();
    chk("post-reset A.q2", int'(qa), 2);

    // B: natural binary rollover 7 -> 0 with a wrap pulse.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 7);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 0);
    tick();
    chk("B rollover q", int'(qb), 0);
    chk("B rollover wrap", int'(wrapb), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
